axi_lite_master: RTL and testbench
==================================

AXI_LITE_MASTER -- requirements
Module: axi_lite_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width; legal values are multiples of 8.
REQ-003 SHALL have parameter TIMEOUT, default 256, response-wait limit in cycles; 0 disables the timeout.
REQ-004 clk  in  1  single clock; all logic is on the rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 cmd_valid  in  1  command request.
REQ-007 cmd_ready  out  1  command accepted.
REQ-008 cmd_we  in  1  1=write, 0=read.
REQ-009 cmd_addr  in  ADDR_W  byte address, passed through unmodified.
REQ-010 cmd_wdata  in  DATA_W  write data.
REQ-011 cmd_wstrb  in  DATA_W/8  write byte strobes.
REQ-012 rsp_valid  out  1  response available.
REQ-013 rsp_ready  in  1  response consumed.
REQ-014 rsp_rdata  out  DATA_W  read data; 0 for writes.
REQ-015 rsp_resp  out  2  BRESP/RRESP, or SLVERR on timeout.
REQ-016 rsp_timeout  out  1  response was produced by timeout.
REQ-017 M_AWADDR/M_AWVALID (out), M_AWREADY (in)  AXI-lite write-address channel.
REQ-018 M_WDATA/M_WSTRB/M_WVALID (out), M_WREADY (in)  write-data channel.
REQ-019 M_BRESP/M_BVALID (in), M_BREADY (out)  write-response channel.
REQ-020 M_ARADDR/M_ARVALID (out), M_ARREADY (in)  read-address channel.
REQ-021 M_RDATA/M_RRESP/M_RVALID (in), M_RREADY (out)  read-data channel.

Function
REQ-022 FSM states SHALL be IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP and RSP.
REQ-023 cmd_ready SHALL be 1 only in IDLE, decoded combinationally from state.
REQ-024 On cmd_valid&&cmd_ready the block SHALL latch addr/wdata/wstrb and go to WR_REQ if cmd_we=1, otherwise RD_REQ.
REQ-025 On entering WR_REQ, M_AWVALID and M_WVALID SHALL both rise on the next cycle.
  - Each valid drops independently, the cycle after its own handshake.
  - Transition to WR_RESP occurs once both handshakes are done; same-cycle handshakes are allowed.
REQ-026 In WR_RESP, M_BREADY SHALL be 1; on M_BVALID, M_BRESP is captured into rsp_resp, rsp_rdata=0, and the FSM goes to RSP.
REQ-027 In RD_REQ, M_ARVALID SHALL be held until M_ARREADY, then the FSM goes to RD_RESP.
REQ-028 In RD_RESP, M_RREADY SHALL be 1; on M_RVALID, RDATA and RRESP are captured and the FSM goes to RSP.
REQ-029 While a VALID is high, its address, data and strobe outputs SHALL be stable; no VALID drops before READY except on timeout or reset.
REQ-030 In RSP, rsp_valid SHALL be 1 and response outputs held until rsp_ready; the FSM then returns to IDLE.
  - Back-to-back commands therefore have at least one IDLE cycle between them.
REQ-031 Timeout counter SHALL clear on command accept and increment each cycle in WR_REQ, WR_RESP, RD_REQ and RD_RESP.
  - On reaching TIMEOUT (TIMEOUT>0), all M_*VALID and M_*READY outputs drop.
  - rsp_resp=2'b10, rsp_timeout=1, rsp_rdata=0; FSM goes to RSP.
  - A handshake completing in that same cycle takes priority over the timeout.
REQ-032 Latency against a slave that is always ready and responds next cycle: accept at cycle 0, AW/W or AR handshake at cycle 1, B or R captured at cycle 2, rsp_valid at cycle 3.

Reset
REQ-033 While rst=1, state SHALL be IDLE and all VALID/READY outputs 0 except cmd_ready=1.
  - rsp_rdata, rsp_resp, rsp_timeout and the counter are 0.
  - Reset mid-transaction abandons the transaction without producing a response.

Structure
REQ-034 Package axi_lite_pkg SHALL hold the RESP_OKAY=2'b00 and RESP_SLVERR=2'b10 constants and the FSM state enum.
REQ-035 The block is a single module with no sub-module.

Verification
REQ-036 Write addr 0x10, data 0xA5A5_1234, strb 0xF, with an always-ready RAM model -> rsp_resp=0 at cycle 3 and RAM word 4 = 0xA5A5_1234.
REQ-037 Read addr 0x10 after REQ-036 -> rsp_rdata=0xA5A5_1234, rsp_resp=0, rsp_timeout=0.
REQ-038 M_AWREADY delayed 3 cycles, M_WREADY immediate -> M_WVALID drops after 1 cycle, M_AWVALID held 4 cycles, with stable payload throughout.
REQ-039 TIMEOUT=8, M_BVALID never asserted -> after 8 cycles rsp_resp=2'b10, rsp_timeout=1, all M_* valids/readies 0.
REQ-040 rsp_ready held low for 5 cycles, then rst asserted mid-RSP -> response held stable until reset; then rsp_valid=0, state IDLE, cmd_ready=1.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: response codes and FSM state encoding shared by the AXI-lite master.
package axi_lite_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP} state_t;
endpackage

// File: rtl/axi_lite_master.sv
// axi_lite_master: single-outstanding command-to-AXI-lite bridge with response-wait timeout.
module axi_lite_master import axi_lite_pkg::*; #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_we,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_resp,
  output logic                rsp_timeout,
  output logic [ADDR_W-1:0]   M_AWADDR,
  output logic                M_AWVALID,
  input  logic                M_AWREADY,
  output logic [DATA_W-1:0]   M_WDATA,
  output logic [DATA_W/8-1:0] M_WSTRB,
  output logic                M_WVALID,
  input  logic                M_WREADY,
  input  logic [1:0]          M_BRESP,
  input  logic                M_BVALID,
  output logic                M_BREADY,
  output logic [ADDR_W-1:0]   M_ARADDR,
  output logic                M_ARVALID,
  input  logic                M_ARREADY,
  input  logic [DATA_W-1:0]   M_RDATA,
  input  logic [1:0]          M_RRESP,
  input  logic                M_RVALID,
  output logic                M_RREADY
);
  localparam logic [31:0] LIMIT = TIMEOUT - 1;
  state_t state;
  logic aw_done, w_done, aw_hs, w_hs, wr_done, hs_done, busy, expire;
  logic [31:0] cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W/8-1:0] wstrb_q;
  always_comb begin
    cmd_ready = state == IDLE;
    rsp_valid = state == RSP;
    M_AWVALID = state == WR_REQ && !aw_done;
    M_WVALID = state == WR_REQ && !w_done;
    M_BREADY = state == WR_RESP;
    M_ARVALID = state == RD_REQ;
    M_RREADY = state == RD_RESP;
    M_AWADDR = addr_q;
    M_ARADDR = addr_q;
    M_WDATA = wdata_q;
    M_WSTRB = wstrb_q;
    aw_hs = M_AWVALID && M_AWREADY;
    w_hs = M_WVALID && M_WREADY;
    wr_done = (aw_done || aw_hs) && (w_done || w_hs);
    busy = state inside {WR_REQ, WR_RESP, RD_REQ, RD_RESP};
    hs_done = state == WR_REQ ? wr_done :
              state == WR_RESP ? M_BVALID :
              state == RD_REQ ? M_ARREADY :
              state == RD_RESP ? M_RVALID : 1'b0;
    // a handshake finishing on the expiry cycle wins over the timeout
    expire = TIMEOUT != 0 && busy && !hs_done && cnt >= LIMIT;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      aw_done <= 1'b0;
      w_done <= 1'b0;
      cnt <= '0;
      rsp_rdata <= '0;
      rsp_resp <= RESP_OKAY;
      rsp_timeout <= 1'b0;
    end else begin
      cnt <= (cmd_valid && cmd_ready) ? '0 : busy ? cnt + 32'd1 : cnt;
      aw_done <= state == IDLE ? 1'b0 : aw_done || aw_hs;
      w_done <= state == IDLE ? 1'b0 : w_done || w_hs;
      if (expire) begin
        state <= RSP;
        rsp_rdata <= '0;
        rsp_resp <= RESP_SLVERR;
        rsp_timeout <= 1'b1;
      end else begin
        case (state)
          IDLE: if (cmd_valid) begin
            addr_q <= cmd_addr;
            wdata_q <= cmd_wdata;
            wstrb_q <= cmd_wstrb;
            state <= cmd_we ? WR_REQ : RD_REQ;
          end
          WR_REQ: if (wr_done) state <= WR_RESP;
          WR_RESP: if (M_BVALID) begin
            rsp_rdata <= '0;
            rsp_resp <= M_BRESP;
            rsp_timeout <= 1'b0;
            state <= RSP;
          end
          RD_REQ: if (M_ARREADY) state <= RD_RESP;
          RD_RESP: if (M_RVALID) begin
            rsp_rdata <= M_RDATA;
            rsp_resp <= M_RRESP;
            rsp_timeout <= 1'b0;
            state <= RSP;
          end
          RSP: if (rsp_ready) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_axi_lite_master.sv
// tb_axi_lite_master: randomized checks of the AXI-lite master against a word-memory reference model.
module tb_axi_lite_master;
  logic clk = 0, rst = 1;
  logic cmd_valid = 0, cmd_ready, cmd_we = 0;
  logic [31:0] cmd_addr = 0, cmd_wdata = 0;
  logic [3:0] cmd_wstrb = 0;
  logic rsp_valid, rsp_ready = 0, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0] rsp_resp;
  logic [31:0] M_AWADDR, M_WDATA, M_ARADDR, M_RDATA = 0;
  logic [3:0] M_WSTRB;
  logic M_AWVALID, M_AWREADY = 0, M_WVALID, M_WREADY = 0, M_BVALID = 0, M_BREADY;
  logic M_ARVALID, M_ARREADY = 0, M_RVALID = 0, M_RREADY;
  logic [1:0] M_BRESP = 0, M_RRESP = 0;
  int n_chk = 0, n_fail = 0;

  axi_lite_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .M_AWADDR(M_AWADDR), .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY), .M_WDATA(M_WDATA),
    .M_WSTRB(M_WSTRB), .M_WVALID(M_WVALID), .M_WREADY(M_WREADY), .M_BRESP(M_BRESP),
    .M_BVALID(M_BVALID), .M_BREADY(M_BREADY), .M_ARADDR(M_ARADDR), .M_ARVALID(M_ARVALID),
    .M_ARREADY(M_ARREADY), .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RVALID(M_RVALID),
    .M_RREADY(M_RREADY)
  );

  always #5 clk = ~clk;

  // slave: per-channel ready delays, RAM of 64 words, response after configurable delay
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic b_never = 0;
  logic [1:0] b_resp = 0, r_resp = 0;
  logic [31:0] sram [0:63];
  logic [31:0] mem [0:63];
  logic [31:0] aw_q = 0, w_q = 0, ar_q = 0;
  logic [3:0] s_q = 0;
  logic got_aw = 0, got_w = 0, got_ar = 0, b_on = 0, r_on = 0;
  int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;

  always begin
    @(posedge clk);
    if (rst) begin
      got_aw = 0; got_w = 0; got_ar = 0; b_on = 0; r_on = 0;
    end else begin
      if (M_AWVALID && M_AWREADY) begin aw_q = M_AWADDR; got_aw = 1; end
      if (M_WVALID && M_WREADY) begin w_q = M_WDATA; s_q = M_WSTRB; got_w = 1; end
      if (M_BVALID && M_BREADY) begin got_aw = 0; got_w = 0; b_on = 0; end
      if (M_ARVALID && M_ARREADY) begin ar_q = M_ARADDR; got_ar = 1; end
      if (M_RVALID && M_RREADY) begin got_ar = 0; r_on = 0; end
    end
    @(negedge clk);
    if (M_AWVALID) begin M_AWREADY = aw_cnt >= aw_dly; aw_cnt++; end else begin M_AWREADY = 0; aw_cnt = 0; end
    if (M_WVALID) begin M_WREADY = w_cnt >= w_dly; w_cnt++; end else begin M_WREADY = 0; w_cnt = 0; end
    if (M_ARVALID) begin M_ARREADY = ar_cnt >= ar_dly; ar_cnt++; end else begin M_ARREADY = 0; ar_cnt = 0; end
    if (got_aw && got_w && !b_on) begin
      for (int i = 0; i < 4; i++) if (s_q[i]) sram[aw_q[7:2]][8*i +: 8] = w_q[8*i +: 8];
      b_on = 1; b_cnt = 0;
    end
    M_BVALID = b_on && !b_never && b_cnt >= b_dly;
    M_BRESP = b_resp;
    if (b_on) b_cnt++;
    if (got_ar && !r_on) begin r_on = 1; r_cnt = 0; M_RDATA = sram[ar_q[7:2]]; end
    M_RVALID = r_on && r_cnt >= r_dly;
    M_RRESP = r_resp;
    if (r_on) r_cnt++;
  end

  // issues one command and waits (bounded) for rsp_valid; lat is the cycle count from accept
  task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       output int lat, output logic [31:0] rd, output logic [1:0] rs, output logic to,
                       output int awc, output int wc, output int bad);
    @(negedge clk);
    cmd_valid = 1; cmd_we = we; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    lat = 0; awc = 0; wc = 0; bad = 0;
    do begin
      @(negedge clk);
      cmd_valid = 0;
      lat++;
      if (M_AWVALID) begin awc++; if (M_AWADDR !== a) bad++; end
      if (M_WVALID) begin wc++; if (M_WDATA !== d || M_WSTRB !== s) bad++; end
      if (M_ARVALID && M_ARADDR !== a) bad++;
    end while (!rsp_valid && lat < 40);
    rd = rsp_rdata; rs = rsp_resp; to = rsp_timeout;
  endtask

  task automatic consume();
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_chk++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready got %b exp 1", cmd_ready); end
    n_chk++; if ({rsp_valid, M_AWVALID, M_WVALID, M_BREADY, M_ARVALID, M_RREADY} !== 6'b0) begin
      n_fail++; $display("FAIL reset_handshakes got %b exp 000000", {rsp_valid, M_AWVALID, M_WVALID, M_BREADY, M_ARVALID, M_RREADY});
    end
    n_chk++; if ({rsp_rdata, rsp_resp, rsp_timeout} !== 35'b0) begin
      n_fail++; $display("FAIL reset_rsp got %h/%b/%b exp 0", rsp_rdata, rsp_resp, rsp_timeout);
    end
    rst = 0;
  endtask

  task automatic test_write_read();
    int lat, awc, wc, bad;
    logic [31:0] rd;
    logic [1:0] rs;
    logic to;
    issue(1, 32'h10, 32'hA5A5_1234, 4'hF, lat, rd, rs, to, awc, wc, bad);
    mem[4] = 32'hA5A5_1234;
    n_chk++; if (lat !== 3) begin n_fail++; $display("FAIL wr_latency got %0d exp 3", lat); end
    n_chk++; if (rs !== 2'b00 || to !== 1'b0 || rd !== 0) begin n_fail++; $display("FAIL wr_rsp got %h/%b/%b exp 0/00/0", rd, rs, to); end
    n_chk++; if (sram[4] !== 32'hA5A5_1234) begin n_fail++; $display("FAIL wr_ram got %h exp a5a51234", sram[4]); end
    consume();
    issue(0, 32'h10, 32'h0, 4'h0, lat, rd, rs, to, awc, wc, bad);
    n_chk++; if (lat !== 3) begin n_fail++; $display("FAIL rd_latency got %0d exp 3", lat); end
    n_chk++; if (rd !== 32'hA5A5_1234 || rs !== 2'b00 || to !== 1'b0) begin
      n_fail++; $display("FAIL rd_rsp got %h/%b/%b exp a5a51234/00/0", rd, rs, to);
    end
    consume();
    n_chk++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rd_return_idle got %b%b exp 10", cmd_ready, rsp_valid); end
  endtask

  task automatic test_aw_delay();
    int lat, awc, wc, bad;
    logic [31:0] rd;
    logic [1:0] rs;
    logic to;
    aw_dly = 3; w_dly = 0;
    issue(1, 32'h24, 32'h1357_9BDF, 4'b0101, lat, rd, rs, to, awc, wc, bad);
    mem[9][7:0] = 8'hDF; mem[9][23:16] = 8'h57;
    n_chk++; if (awc !== 4) begin n_fail++; $display("FAIL awvalid_cycles got %0d exp 4", awc); end
    n_chk++; if (wc !== 1) begin n_fail++; $display("FAIL wvalid_cycles got %0d exp 1", wc); end
    n_chk++; if (bad !== 0) begin n_fail++; $display("FAIL aw_payload_stable got %0d exp 0", bad); end
    n_chk++; if (lat !== 6) begin n_fail++; $display("FAIL aw_delay_latency got %0d exp 6", lat); end
    consume();
    aw_dly = 0;
  endtask

  task automatic test_random();
    int lat, awc, wc, bad, idx, exp_lat;
    logic we, to;
    logic [31:0] d, rd, exp_rd;
    logic [3:0] s;
    logic [1:0] rs, exp_rs;
    for (int n = 0; n < 24; n++) begin
      we = 1'($urandom_range(0, 1)); idx = $urandom_range(0, 63); d = $urandom; s = 4'($urandom);
      aw_dly = $urandom_range(0, 2); w_dly = $urandom_range(0, 2); b_dly = $urandom_range(0, 2);
      ar_dly = $urandom_range(0, 2); r_dly = $urandom_range(0, 2);
      b_resp = 2'($urandom); r_resp = 2'($urandom);
      exp_lat = we ? (aw_dly > w_dly ? aw_dly : w_dly) + b_dly + 3 : ar_dly + r_dly + 3;
      exp_rs = we ? b_resp : r_resp;
      exp_rd = we ? 32'h0 : mem[idx];
      if (we) for (int i = 0; i < 4; i++) if (s[i]) mem[idx][8*i +: 8] = d[8*i +: 8];
      issue(we, 32'(idx) << 2, d, s, lat, rd, rs, to, awc, wc, bad);
      n_chk++; if (lat !== exp_lat) begin n_fail++; $display("FAIL rnd%0d_latency got %0d exp %0d", n, lat, exp_lat); end
      n_chk++; if (rd !== exp_rd || rs !== exp_rs || to !== 1'b0) begin
        n_fail++; $display("FAIL rnd%0d_rsp we=%b got %h/%b/%b exp %h/%b/0", n, we, rd, rs, to, exp_rd, exp_rs);
      end
      n_chk++; if (bad !== 0) begin n_fail++; $display("FAIL rnd%0d_payload got %0d exp 0", n, bad); end
      consume();
    end
    aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0; b_resp = 0; r_resp = 0;
  endtask

  task automatic test_timeout();
    int lat, awc, wc, bad;
    logic [31:0] rd;
    logic [1:0] rs;
    logic to;
    b_never = 1;
    issue(1, 32'h40, 32'hDEAD_BEEF, 4'hF, lat, rd, rs, to, awc, wc, bad);
    mem[16] = 32'hDEAD_BEEF;
    n_chk++; if (lat !== 9) begin n_fail++; $display("FAIL timeout_latency got %0d exp 9", lat); end
    n_chk++; if (rs !== 2'b10 || to !== 1'b1 || rd !== 0) begin n_fail++; $display("FAIL timeout_rsp got %h/%b/%b exp 0/10/1", rd, rs, to); end
    n_chk++; if ({M_AWVALID, M_WVALID, M_BREADY, M_ARVALID, M_RREADY} !== 5'b0) begin
      n_fail++; $display("FAIL timeout_channels got %b exp 00000", {M_AWVALID, M_WVALID, M_BREADY, M_ARVALID, M_RREADY});
    end
    consume();
    b_never = 0;
    rst = 1; @(negedge clk); rst = 0;
    issue(0, 32'h40, 32'h0, 4'h0, lat, rd, rs, to, awc, wc, bad);
    n_chk++; if (rd !== mem[16] || rs !== 2'b00 || to !== 1'b0) begin
      n_fail++; $display("FAIL post_timeout_read got %h/%b/%b exp %h/00/0", rd, rs, to, mem[16]);
    end
    consume();
  endtask

  task automatic test_hold_reset();
    int lat, awc, wc, bad;
    logic [31:0] rd;
    logic [1:0] rs;
    logic to;
    r_resp = 2'b01;
    issue(0, 32'h10, 32'h0, 4'h0, lat, rd, rs, to, awc, wc, bad);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_chk++; if (rsp_valid !== 1'b1 || rsp_rdata !== mem[4] || rsp_resp !== 2'b01 || rsp_timeout !== 1'b0) begin
        n_fail++; $display("FAIL hold%0d got %b/%h/%b/%b exp 1/%h/01/0", c, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout, mem[4]);
      end
    end
    rst = 1;
    @(negedge clk);
    n_chk++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_rsp got %b%b exp 01", rsp_valid, cmd_ready); end
    n_chk++; if (rsp_resp !== 2'b00 || rsp_rdata !== 0) begin n_fail++; $display("FAIL rst_mid_rsp_data got %h/%b exp 0/00", rsp_rdata, rsp_resp); end
    rst = 0; r_resp = 0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin sram[i] = 0; mem[i] = 0; end
    test_reset();
    test_write_read();
    test_aw_delay();
    test_random();
    test_timeout();
    test_hold_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
